// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side handshake and shared register view for reg_write_arbiter
interface reg_write_arbiter_if #(
    parameter int p_nreqs = 4,
    parameter int p_nbits = 8
);
    localparam int ow = $clog2(p_nreqs);
    logic                       hold;
    logic [p_nreqs-1:0]         req_val;
    logic [p_nreqs-1:0]         req_rdy;
    logic [p_nreqs*p_nbits-1:0] req_msg;
    logic [p_nbits-1:0]         q;
    logic [ow-1:0]              q_owner;
    logic                       q_updated;
    modport master (output hold, req_val, req_msg, input req_rdy, q, q_owner, q_updated);
    modport slave (input hold, req_val, req_msg, output req_rdy, q, q_owner, q_updated);
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin val/rdy arbiter sharing one register among p_nreqs writers
module reg_write_arbiter #(
    parameter int                 p_nreqs       = 4,
    parameter int                 p_nbits       = 8,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input logic                clk,
    input logic                reset,
    reg_write_arbiter_if.slave bus
);
    localparam int ow = $clog2(p_nreqs);
    logic [ow-1:0]      ptr, winner, idx, q_owner;
    logic [p_nbits-1:0] q;
    logic               found, xfer, q_updated;
    // Scan from ptr upward; iterating backwards lets the smallest offset win last
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = p_nreqs - 1; k >= 0; k--) begin
            idx = ow'((int'(ptr) + k) % p_nreqs);
            if (bus.req_val[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
    assign xfer          = found && !bus.hold && !reset;
    assign bus.req_rdy   = xfer ? p_nreqs'(1) << winner : '0;
    assign bus.q         = q;
    assign bus.q_owner   = q_owner;
    assign bus.q_updated = q_updated;
    // Register write on transfer; pointer moves just past the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= p_reset_value;
            q_owner   <= '0;
            q_updated <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            q         <= bus.req_msg[winner*p_nbits +: p_nbits];
            q_owner   <= winner;
            q_updated <= 1'b1;
            ptr       <= (winner == ow'(p_nreqs - 1)) ? '0 : winner + 1'b1;
        end else begin
            q_updated <= 1'b0;
        end
    end
    assert property (@(posedge clk) disable iff (reset) !$isunknown({bus.req_val, bus.hold}));
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.p_nreqs(4), .p_nbits(8)) bus();
    reg_write_arbiter #(.p_nreqs(4), .p_nbits(8), .p_reset_value(8'h00)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [1:0] owner;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] msg[4];
    logic [7:0] last_q;

    // Drive one cycle of stimulus at the falling edge; g is the expected grant or -1
    task automatic drive(input logic [3:0] val, input logic h, input int g);
        @(negedge clk);
        bus.req_val = val;
        bus.hold    = h;
        bus.req_msg = {msg[3], msg[2], msg[1], msg[0]};
        if (g >= 0) begin
            sb.push_back('{msg[g], 2'(g)});
            last_q = msg[g];
        end
    endtask

    task automatic rand_msgs();
        for (int i = 0; i < 4; i++) msg[i] = 8'($urandom_range(1, 255));
    endtask

    // Each edge after reset either completes the oldest expected write or shows no write
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (bus.q_updated !== 1'b1 || bus.q !== e.q || bus.q_owner !== e.owner) begin
                    n_err++;
                    $display("FAIL write: got updated=%b q=%h owner=%0d, want updated=1 q=%h owner=%0d",
                             bus.q_updated, bus.q, bus.q_owner, e.q, e.owner);
                end
            end else begin
                n_cmp++;
                if (bus.q_updated !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_updated: got %b want 0", bus.q_updated);
                end
            end
        end
    end

    task automatic test_reset();
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0000) begin
            n_err++;
            $display("FAIL rdy_in_reset: got %b want 0000", bus.req_rdy);
        end
        @(negedge clk);
        reset       = 1'b0;
        bus.req_val = 4'b0000;
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0000 || bus.q !== 8'h00 || bus.q_owner !== 2'd0 || bus.q_updated !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b q=%h owner=%0d upd=%b want 0000 00 0 0",
                     bus.req_rdy, bus.q, bus.q_owner, bus.q_updated);
        end
    endtask

    task automatic test_single();
        rand_msgs();
        msg[2] = 8'hA5;
        drive(4'b0100, 1'b0, 2);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0100) begin
            n_err++;
            $display("FAIL single_rdy: got %b want 0100", bus.req_rdy);
        end
        drive(4'b0000, 1'b0, -1);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0000 || bus.q !== 8'hA5 || bus.q_owner !== 2'd2) begin
            n_err++;
            $display("FAIL single_q: got rdy=%b q=%h owner=%0d want 0000 a5 2",
                     bus.req_rdy, bus.q, bus.q_owner);
        end
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        rand_msgs();
        drive(4'b1000, 1'b0, 3);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b1000) begin
            n_err++;
            $display("FAIL rr_setup_rdy: got %b want 1000", bus.req_rdy);
        end
        for (int i = 0; i < 5; i++) begin
            rand_msgs();
            drive(4'b1111, 1'b0, exp_g[i]);
            #1;
            n_cmp++;
            if (bus.req_rdy !== 4'(1 << exp_g[i])) begin
                n_err++;
                $display("FAIL rr_rdy[%0d]: got %b want %b", i, bus.req_rdy, 4'(1 << exp_g[i]));
            end
        end
    endtask

    task automatic test_wrap();
        int exp_g[3] = '{3, 0, 3};
        rand_msgs();
        drive(4'b0100, 1'b0, 2);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0100) begin
            n_err++;
            $display("FAIL wrap_setup_rdy: got %b want 0100", bus.req_rdy);
        end
        for (int i = 0; i < 3; i++) begin
            rand_msgs();
            drive(4'b1001, 1'b0, exp_g[i]);
            #1;
            n_cmp++;
            if (bus.req_rdy !== 4'(1 << exp_g[i])) begin
                n_err++;
                $display("FAIL wrap_rdy[%0d]: got %b want %b", i, bus.req_rdy, 4'(1 << exp_g[i]));
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] q_before;
        q_before = last_q;
        for (int i = 0; i < 2; i++) begin
            rand_msgs();
            drive(4'b1111, 1'b1, -1);
            #1;
            n_cmp++;
            if (bus.req_rdy !== 4'b0000) begin
                n_err++;
                $display("FAIL hold_rdy[%0d]: got %b want 0000", i, bus.req_rdy);
            end
        end
        n_cmp++;
        if (bus.q !== q_before || bus.q_owner !== 2'd3 || bus.q_updated !== 1'b0) begin
            n_err++;
            $display("FAIL hold_state: got q=%h owner=%0d upd=%b want %h 3 0",
                     bus.q, bus.q_owner, bus.q_updated, q_before);
        end
        rand_msgs();
        drive(4'b1111, 1'b0, 0);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0001) begin
            n_err++;
            $display("FAIL hold_release_rdy: got %b want 0001", bus.req_rdy);
        end
    endtask

    task automatic test_reset_mid();
        rand_msgs();
        msg[2] = 8'h3C;
        drive(4'b0100, 1'b0, 2);
        drive(4'b0010, 1'b0, -1);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.q !== 8'h00 || bus.q_owner !== 2'd0 || bus.req_rdy !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: got q=%h owner=%0d rdy=%b want 00 0 0000",
                     bus.q, bus.q_owner, bus.req_rdy);
        end
        @(negedge clk);
        reset       = 1'b0;
        bus.req_val = 4'b0000;
        rand_msgs();
        drive(4'b1010, 1'b0, 1);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0010) begin
            n_err++;
            $display("FAIL post_reset_rdy: got %b want 0010", bus.req_rdy);
        end
        rand_msgs();
        drive(4'b0010, 1'b0, 1);
        #1;
        n_cmp++;
        if (bus.req_rdy !== 4'b0010) begin
            n_err++;
            $display("FAIL post_reset_rdy2: got %b want 0010", bus.req_rdy);
        end
        drive(4'b0000, 1'b0, -1);
        @(negedge clk);
    endtask

    initial begin
        bus.hold    = 1'b0;
        bus.req_val = 4'b1111;
        bus.req_msg = '0;
        last_q      = 8'h00;
        for (int i = 0; i < 4; i++) msg[i] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hold();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
